// File: rtl/alu_pkg.sv
// Purpose : opcodes, FSM state encoding and opcode helpers shared by the ALU pipe files.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Purpose : operand/result handshake bundle between register-read and writeback.
// Latency : n/a (wiring only).
// Backpr. : in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Signals : in_valid, in_ready, src1, src2, alu_ctrl (request); out_valid, out_ready,
//           result, zero, cout, overflow, illegal (response).
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [3:0]       alu_ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;
    logic             illegal;

    // ALU side
    modport slave (
        input  in_valid, src1, src2, alu_ctrl, out_ready,
        output in_ready, out_valid, result, zero, cout, overflow, illegal
    );

    // Producer/consumer side
    modport master (
        output in_valid, src1, src2, alu_ctrl, out_ready,
        input  in_ready, out_valid, result, zero, cout, overflow, illegal
    );
endinterface

// File: rtl/alu_core.sv
// Purpose : combinational logic/adder unit for the single-cycle ALU codes.
// Latency : 0 (purely combinational).
// Backpr. : none; the caller registers the outputs.
// Ports   : i_a, i_b operands; i_ctrl opcode; o_res result; o_cout adder carry (ADD/SUB/SLT);
//           o_ovf signed overflow (ADD/SUB); o_illegal for any code not handled here.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_ctrl,
    output logic [WIDTH-1:0] o_res,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_illegal
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum_full;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf_raw;

    // SUB and SLT share the adder as A + ~B + 1.
    assign w_sub      = (i_ctrl == ALU_SUB) || (i_ctrl == ALU_SLT);
    assign w_b_eff    = w_sub ? ~i_b : i_b;
    assign w_sum_full = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    assign w_sum      = w_sum_full[WIDTH-1:0];
    assign w_ovf_raw  = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

    always_comb begin
        o_res     = '0;
        o_cout    = 1'b0;
        o_ovf     = 1'b0;
        o_illegal = 1'b0;
        case (i_ctrl)
            ALU_AND: o_res = i_a & i_b;
            ALU_OR:  o_res = i_a | i_b;
            ALU_NOR: o_res = ~(i_a | i_b);
            ALU_ADD, ALU_SUB: begin
                o_res  = w_sum;
                o_cout = w_sum_full[WIDTH];
                o_ovf  = w_ovf_raw;
            end
            ALU_SLT: begin
                // Sign of the true difference: the sum's msb is wrong exactly when it overflowed.
                o_res  = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf_raw};
                o_cout = w_sum_full[WIDTH];
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Purpose : handshaked ALU with registered result/flags; shifts iterate 1 bit/cycle when ALU_SHIFT_EN is defined.
// Latency : 1 cycle for single-cycle codes; shift by k takes k+1 cycles (ALU_SHIFT_EN only).
// Backpr. : result held until out_ready; in_ready = out_ready while holding, 0 while shifting.
// Ports   : clk, rst_n (async active-low); bus (alu_pipe_if.slave) carrying the request and response.
// Config  : ALU_SHIFT_EN enables SLL/SRL/SRA, the BUSY state and shift counter; otherwise those codes are illegal.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_pipe_if.slave    bus
);

    state_t           r_state;
    state_t           w_nxt_state;
    state_t           w_acc_dst;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cout;
    logic             r_ovf;
    logic             r_illegal;

    logic [WIDTH-1:0] w_core_res;
    logic             w_core_cout;
    logic             w_core_ovf;
    logic             w_core_ill;

    logic [WIDTH-1:0] w_ld_res;
    logic             w_ld_cout;
    logic             w_ld_ovf;
    logic             w_ld_ill;

`ifdef ALU_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   r_cnt;
    logic [1:0]       r_shop;
    logic [SHW-1:0]   w_amt;
    logic             w_is_shift;
    logic [WIDTH-1:0] w_shifted;

    assign w_is_shift = is_shift_op(bus.alu_ctrl);
    assign w_amt      = bus.src2[SHW-1:0];
`endif

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_a       (bus.src1),
        .i_b       (bus.src2),
        .i_ctrl    (bus.alu_ctrl),
        .o_res     (w_core_res),
        .o_cout    (w_core_cout),
        .o_ovf     (w_core_ovf),
        .o_illegal (w_core_ill)
    );

    assign w_accept = bus.in_valid & w_in_ready;

    // What gets loaded into the result register on accept, and where the FSM goes.
    always_comb begin
        w_ld_res  = w_core_res;
        w_ld_cout = w_core_cout;
        w_ld_ovf  = w_core_ovf;
        w_ld_ill  = w_core_ill;
        w_acc_dst = HOLD;
`ifdef ALU_SHIFT_EN
        if (w_is_shift) begin
            // The result register doubles as the shift working register.
            w_ld_res  = bus.src1;
            w_ld_cout = 1'b0;
            w_ld_ovf  = 1'b0;
            w_ld_ill  = 1'b0;
            if (w_amt != '0) begin
                w_acc_dst = BUSY;
            end
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nxt_state = w_acc_dst;
                end
            end
            BUSY: begin
`ifdef ALU_SHIFT_EN
                if (r_cnt == SHW'(1)) begin
                    w_nxt_state = HOLD;
                end
`else
                w_nxt_state = IDLE;
`endif
            end
            HOLD: begin
                if (w_accept) begin
                    w_nxt_state = w_acc_dst;
                end else if (bus.out_ready) begin
                    w_nxt_state = IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: w_in_ready = 1'b1;
            HOLD: begin
                w_out_valid = 1'b1;
                w_in_ready  = bus.out_ready;
            end
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    // Result and flags; zero is derived from the value being written so it never lags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_result  <= w_ld_res;
            r_zero    <= (w_ld_res == '0);
            r_cout    <= w_ld_cout;
            r_ovf     <= w_ld_ovf;
            r_illegal <= w_ld_ill;
        end
`ifdef ALU_SHIFT_EN
        else if (r_state == BUSY) begin
            r_result <= w_shifted;
            r_zero   <= (w_shifted == '0);
        end
`endif
    end

`ifdef ALU_SHIFT_EN
    // One-bit step; SRA keeps the msb, which is still the original sign bit.
    always_comb begin
        case (r_shop)
            2'b00:   w_shifted = {r_result[WIDTH-2:0], 1'b0};
            2'b01:   w_shifted = {1'b0, r_result[WIDTH-1:1]};
            default: w_shifted = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_shop <= 2'b00;
        end else if (w_accept) begin
            r_cnt  <= w_amt;
            r_shop <= bus.alu_ctrl[1:0];
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - SHW'(1);
        end
    end
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;
    assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Purpose : directed-vector bench for alu_pipe with a queue scoreboard and independent output monitor.
// Latency : checks 1-cycle ops, k+1-cycle shifts (ALU_SHIFT_EN), back-to-back and backpressure behaviour.
// Backpr. : drives out_ready low for a hold window and checks result stability and in_ready.
module tb_alu_pipe;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(32)) bus ();

    alu_pipe #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_pop = -10;
    int   run      = 0;
    int   max_run  = 0;
    int   n_ret    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [31:0] r, input logic z, input logic c,
                                input logic o, input logic ill);
        exp_t e;
        e.res = r; e.z = z; e.c = c; e.o = o; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every retire.
    initial begin
        exp_t got;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                got = {bus.result, bus.zero, bus.cout, bus.overflow, bus.illegal};
                if (sb.size() == 0) begin
                    chk("unexpected_output", 64'(got), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    chk("result_flags", 64'(got), 64'(e));
                end
                n_ret++;
                if (last_pop == cyc - 1) run++;
                else run = 1;
                if (run > max_run) max_run = run;
                last_pop = cyc;
            end
        end
    end

    // Presents one op and waits for the accept edge; returns at posedge+1 with in_valid low.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c, input exp_t e);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.src1     = a;
        bus.src2     = b;
        bus.alu_ctrl = c;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (bus.in_ready !== 1'b1) begin
            chk("send_accept_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb.push_back(e);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ret0;
        int seen;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.alu_ctrl  = 4'b0000;
        bus.out_ready = 1'b1;

        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result",    64'(bus.result),    64'd0);
        chk("rst_flags",     64'({bus.zero, bus.cout, bus.overflow, bus.illegal}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // ADD signed overflow, 1-cycle latency
        send(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, mk(32'h8000_0000, 0, 0, 1, 0));
        @(negedge clk);
        chk("add_latency_valid", 64'(bus.out_valid), 64'd1);
        drain();

        send(32'h0000_0005, 32'h0000_0005, 4'b0110, mk(32'h0, 1, 1, 0, 0));   // SUB equal
        send(32'h8000_0000, 32'h0000_0001, 4'b0111, mk(32'h1, 0, 1, 0, 0));   // SLT across overflow
        send(32'h0000_0001, 32'h8000_0000, 4'b0111, mk(32'h0, 1, 0, 0, 0));   // SLT reversed
        send(32'h0000_0000, 32'h0000_0001, 4'b0110, mk(32'hFFFF_FFFF, 0, 0, 0, 0)); // SUB borrow
        send(32'h0000_000F, 32'h0000_00F0, 4'b0001, mk(32'h0000_00FF, 0, 0, 0, 0)); // OR
        send(32'h0000_0000, 32'h0000_0000, 4'b1100, mk(32'hFFFF_FFFF, 0, 0, 0, 0)); // NOR
        send(32'hFFFF_FFFF, 32'h0000_0000, 4'b1100, mk(32'h0, 1, 0, 0, 0));   // NOR -> zero
        send(32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, mk(32'h0, 1, 1, 0, 0));   // ADD carry, no ovf
        send(32'h1234_5678, 32'h0000_0000, 4'b0101, mk(32'h0, 1, 0, 0, 1));   // illegal 0x5
        drain();

        // Back-to-back throughput
        max_run = 0;
        ret0    = n_ret;
        for (int i = 0; i < 8; i++) begin
            send(32'(i), 32'h0000_0010, 4'b0010, mk(32'(i + 16), 0, 0, 0, 0));
        end
        drain();
        chk("b2b_count",       64'(n_ret - ret0), 64'd8);
        chk("b2b_consecutive", 64'(max_run),      64'd8);

        // Backpressure: result held, in_ready low, operands captured at accept
        bus.out_ready = 1'b0;
        send(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, mk(32'hF000_F000, 0, 0, 0, 0));
        bus.src1 = 32'h0;
        bus.src2 = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid",    64'(bus.out_valid), 64'd1);
            chk("bp_result",   64'(bus.result),    64'hF000_F000);
            chk("bp_in_ready", 64'(bus.in_ready),  64'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drain();

`ifdef ALU_SHIFT_EN
        // SRA by 4: four busy cycles then valid
        send(32'h8000_0000, 32'h0000_0004, 4'b1010, mk(32'hF800_0000, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sra_busy_vld_rdy", 64'({bus.out_valid, bus.in_ready}), 64'd0);
        end
        @(negedge clk);
        chk("sra_latency_valid", 64'(bus.out_valid), 64'd1);
        drain();

        // SLL by 0 (upper src2 bits ignored): 1-cycle latency
        send(32'h0000_0001, 32'h0000_0020, 4'b1000, mk(32'h1, 0, 0, 0, 0));
        @(negedge clk);
        chk("sll0_latency_valid", 64'(bus.out_valid), 64'd1);
        drain();

        send(32'hF000_0000, 32'd28,        4'b1001, mk(32'h0000_000F, 0, 0, 0, 0)); // SRL
        send(32'h8000_0001, 32'd1,         4'b1000, mk(32'h0000_0002, 0, 0, 0, 0)); // SLL
        send(32'h8000_0000, 32'd1,         4'b1000, mk(32'h0, 1, 0, 0, 0));         // SLL to zero
        drain();

        // Reset while BUSY
        send(32'h8000_0000, 32'd10, 4'b1010, mk(32'hFFE0_0000, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
`else
        // Shift codes are illegal without the shifter
        send(32'h0000_0001, 32'h0000_0004, 4'b1000, mk(32'h0, 1, 0, 0, 1));
        send(32'h8000_0000, 32'h0000_0004, 4'b1010, mk(32'h0, 1, 0, 0, 1));
        drain();

        // Reset while HOLD
        bus.out_ready = 1'b0;
        send(32'h0000_0001, 32'h0000_0001, 4'b0010, mk(32'h2, 0, 0, 0, 0));
        @(negedge clk);
`endif
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_result",    64'(bus.result),    64'd0);
        chk("midrst_flags",     64'({bus.zero, bus.cout, bus.overflow, bus.illegal}), 64'd0);
        if (sb.size() != 0) void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        chk("midrst_no_valid", 64'(seen), 64'd0);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Still operational after reset
        @(posedge clk); #1;
        send(32'h0000_0003, 32'h0000_0004, 4'b0010, mk(32'h7, 0, 0, 0, 0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
